id_ex_interlock: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use interlock for the 5-stage RISC-V core. It sits between decode (register-file read) and execute. Each cycle it selects the final ra/rb operands from the register file, the EX result or the MEM result/load data, and captures them into the EX stage. When the decoded instruction needs the destination of a load still in EX, it stalls decode for one cycle and inserts a bubble. It also counts interlock stall cycles for performance monitoring.

---
 rtl/id_ex_if.sv | 59 +++++
 rtl/id_ex_interlock.sv | 133 +++++++++++++
 tb/tb_id_ex_interlock.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decode operands/control, EX/MEM forwarding sources, and the
// registered EX-stage outputs of the interlock.
interface id_ex_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned CNT_W  = 16
);
  // Decode stage
  logic              id_valid_i;
  logic [RIDX_W-1:0] id_ra_index_i;
  logic [RIDX_W-1:0] id_rb_index_i;
  logic              id_ra_used_i;
  logic              id_rb_used_i;
  logic [XLEN-1:0]   id_ra_value_i;
  logic [XLEN-1:0]   id_rb_value_i;
  logic [RIDX_W-1:0] id_rd_index_i;
  logic              id_rd_wr_i;
  logic              id_load_i;

  // Forwarding sources
  logic [XLEN-1:0]   ex_alu_res_i;
  logic [RIDX_W-1:0] mem_rd_index_i;
  logic              mem_rd_wr_i;
  logic              mem_access_i;
  logic [XLEN-1:0]   mem_alu_res_i;
  logic [XLEN-1:0]   mem_rdata_i;

  // Pipeline control
  logic              ex_stall_i;
  logic              flush_i;

  // Outputs
  logic              id_stall_o;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_ra_o;
  logic [XLEN-1:0]   ex_rb_o;
  logic [RIDX_W-1:0] ex_rd_index_o;
  logic              ex_rd_wr_o;
  logic              ex_load_o;
  logic [CNT_W-1:0]  stall_count_o;

  modport slave (
    input  id_valid_i, id_ra_index_i, id_rb_index_i, id_ra_used_i, id_rb_used_i,
    input  id_ra_value_i, id_rb_value_i, id_rd_index_i, id_rd_wr_i, id_load_i,
    input  ex_alu_res_i, mem_rd_index_i, mem_rd_wr_i, mem_access_i, mem_alu_res_i,
    input  mem_rdata_i, ex_stall_i, flush_i,
    output id_stall_o, ex_valid_o, ex_ra_o, ex_rb_o, ex_rd_index_o, ex_rd_wr_o,
    output ex_load_o, stall_count_o
  );

  modport master (
    output id_valid_i, id_ra_index_i, id_rb_index_i, id_ra_used_i, id_rb_used_i,
    output id_ra_value_i, id_rb_value_i, id_rd_index_i, id_rd_wr_i, id_load_i,
    output ex_alu_res_i, mem_rd_index_i, mem_rd_wr_i, mem_access_i, mem_alu_res_i,
    output mem_rdata_i, ex_stall_i, flush_i,
    input  id_stall_o, ex_valid_o, ex_ra_o, ex_rb_o, ex_rd_index_o, ex_rd_wr_o,
    input  ex_load_o, stall_count_o
  );
endinterface

// File: rtl/id_ex_interlock.sv
// ID/EX pipeline register with EX/MEM operand forwarding, a one-bubble load-use interlock
// and a saturating count of interlock stall cycles.
module id_ex_interlock #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic    clk_i,
  input logic    reset_ni,
  id_ex_if.slave pipe_io
);

  typedef enum logic {StRun, StBubble} state_e;

  state_e            state_q, state_d;
  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_ra_q, ex_ra_d;
  logic [XLEN-1:0]   ex_rb_q, ex_rb_d;
  logic [RIDX_W-1:0] ex_rd_index_q;
  logic              ex_rd_wr_q;
  logic              ex_load_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic ex_hit_a, ex_hit_b;
  logic mem_hit_a, mem_hit_b;
  logic load_use;
  logic enter_bubble;

  // Hazard detection; register x0 never aliases a producer.
  always_comb begin
    ex_hit_a  = ex_valid_q & ex_rd_wr_q & (ex_rd_index_q == pipe_io.id_ra_index_i) &
                (pipe_io.id_ra_index_i != '0);
    ex_hit_b  = ex_valid_q & ex_rd_wr_q & (ex_rd_index_q == pipe_io.id_rb_index_i) &
                (pipe_io.id_rb_index_i != '0);
    mem_hit_a = pipe_io.mem_rd_wr_i & (pipe_io.mem_rd_index_i == pipe_io.id_ra_index_i) &
                (pipe_io.id_ra_index_i != '0);
    mem_hit_b = pipe_io.mem_rd_wr_i & (pipe_io.mem_rd_index_i == pipe_io.id_rb_index_i) &
                (pipe_io.id_rb_index_i != '0);
    load_use  = pipe_io.id_valid_i & ex_load_q &
                ((ex_hit_a & pipe_io.id_ra_used_i) | (ex_hit_b & pipe_io.id_rb_used_i));
  end

  // Operand select: youngest producer first. A load in EX has no data yet, so a matching
  // EX load falls through to MEM/regfile (the interlock covers the used case).
  always_comb begin
    ex_ra_d = pipe_io.id_ra_value_i;
    if (ex_hit_a && !ex_load_q) begin
      ex_ra_d = pipe_io.ex_alu_res_i;
    end else if (mem_hit_a) begin
      ex_ra_d = pipe_io.mem_access_i ? pipe_io.mem_rdata_i : pipe_io.mem_alu_res_i;
    end
  end

  always_comb begin
    ex_rb_d = pipe_io.id_rb_value_i;
    if (ex_hit_b && !ex_load_q) begin
      ex_rb_d = pipe_io.ex_alu_res_i;
    end else if (mem_hit_b) begin
      ex_rb_d = pipe_io.mem_access_i ? pipe_io.mem_rdata_i : pipe_io.mem_alu_res_i;
    end
  end

  // Interlock FSM and stall counter next state.
  always_comb begin
    state_d      = state_q;
    enter_bubble = 1'b0;
    cnt_d        = cnt_q;
    unique case (state_q)
      StRun: begin
        if (load_use && !pipe_io.ex_stall_i && !pipe_io.flush_i) begin
          state_d      = StBubble;
          enter_bubble = 1'b1;
        end
      end
      StBubble: begin
        if (!pipe_io.ex_stall_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (enter_bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX register: freeze > flush > bubble > capture. Data fields hold on kill/bubble.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ex_valid_q    <= 1'b0;
      ex_rd_wr_q    <= 1'b0;
      ex_load_q     <= 1'b0;
      ex_ra_q       <= '0;
      ex_rb_q       <= '0;
      ex_rd_index_q <= '0;
    end else if (pipe_io.ex_stall_i) begin
      ex_valid_q    <= ex_valid_q;
      ex_rd_wr_q    <= ex_rd_wr_q;
      ex_load_q     <= ex_load_q;
    end else if (pipe_io.flush_i || load_use) begin
      ex_valid_q    <= 1'b0;
      ex_rd_wr_q    <= 1'b0;
      ex_load_q     <= 1'b0;
    end else begin
      ex_valid_q    <= pipe_io.id_valid_i;
      ex_rd_wr_q    <= pipe_io.id_valid_i & pipe_io.id_rd_wr_i;
      ex_load_q     <= pipe_io.id_valid_i & pipe_io.id_load_i;
      ex_ra_q       <= ex_ra_d;
      ex_rb_q       <= ex_rb_d;
      ex_rd_index_q <= pipe_io.id_rd_index_i;
    end
  end

  assign pipe_io.id_stall_o    = pipe_io.ex_stall_i | (load_use & ~pipe_io.flush_i);
  assign pipe_io.ex_valid_o    = ex_valid_q;
  assign pipe_io.ex_ra_o       = ex_ra_q;
  assign pipe_io.ex_rb_o       = ex_rb_q;
  assign pipe_io.ex_rd_index_o = ex_rd_index_q;
  assign pipe_io.ex_rd_wr_o    = ex_rd_wr_q;
  assign pipe_io.ex_load_o     = ex_load_q;
  assign pipe_io.stall_count_o = cnt_q;

endmodule

// File: tb/tb_id_ex_interlock.sv
// Bench for id_ex_interlock: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural pipeline model.
module tb_id_ex_interlock;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset_ni;
  int   total = 0;
  int   bad   = 0;

  id_ex_if #(.XLEN(XLEN), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) bus ();

  id_ex_interlock #(.XLEN(XLEN), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) u_dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .pipe_io (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what sits in EX and how many interlock bubbles were spent.
  logic        m_valid, m_rd_wr, m_load;
  logic [31:0] m_ra, m_rb;
  logic [4:0]  m_rd;
  int          m_cnt;

  // Value the instruction in ID should see for a source register.
  function automatic logic [31:0] want_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (m_valid && m_rd_wr && !m_load && m_rd == idx) return bus.ex_alu_res_i;
    if (bus.mem_rd_wr_i && bus.mem_rd_index_i == idx)
      return bus.mem_access_i ? bus.mem_rdata_i : bus.mem_alu_res_i;
    return rf;
  endfunction

  function automatic logic model_load_use();
    logic need_a, need_b;
    need_a = bus.id_ra_used_i && bus.id_ra_index_i != 0 && bus.id_ra_index_i == m_rd;
    need_b = bus.id_rb_used_i && bus.id_rb_index_i != 0 && bus.id_rb_index_i == m_rd;
    return bus.id_valid_i && m_valid && m_rd_wr && m_load && (need_a || need_b);
  endfunction

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_valid <= 0; m_rd_wr <= 0; m_load <= 0;
      m_ra <= 0; m_rb <= 0; m_rd <= 0; m_cnt <= 0;
    end else if (bus.ex_stall_i) begin
      m_valid <= m_valid;
    end else if (bus.flush_i) begin
      m_valid <= 0; m_rd_wr <= 0; m_load <= 0;
    end else if (model_load_use()) begin
      m_valid <= 0; m_rd_wr <= 0; m_load <= 0;
      m_cnt   <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    end else begin
      m_valid <= bus.id_valid_i;
      m_rd_wr <= bus.id_valid_i && bus.id_rd_wr_i;
      m_load  <= bus.id_valid_i && bus.id_load_i;
      m_ra    <= want_operand(bus.id_ra_index_i, bus.id_ra_value_i);
      m_rb    <= want_operand(bus.id_rb_index_i, bus.id_rb_value_i);
      m_rd    <= bus.id_rd_index_i;
    end
  end

  // Per-cycle comparison, well after inputs settle and away from the clock edge.
  always @(negedge clk) begin
    #2;
    check("id_stall", 32'(bus.id_stall_o),
          32'(bus.ex_stall_i || (model_load_use() && !bus.flush_i)));
    check("ex_valid", 32'(bus.ex_valid_o), 32'(m_valid));
    check("ex_rd_wr", 32'(bus.ex_rd_wr_o), 32'(m_rd_wr));
    check("ex_load", 32'(bus.ex_load_o), 32'(m_load));
    check("stall_count", 32'(bus.stall_count_o), 32'(m_cnt));
    if (m_valid) begin
      check("ex_ra", bus.ex_ra_o, m_ra);
      check("ex_rb", bus.ex_rb_o, m_rb);
      check("ex_rd_index", 32'(bus.ex_rd_index_o), 32'(m_rd));
    end
  end

  task automatic idle();
    bus.id_valid_i = 0; bus.id_ra_index_i = 0; bus.id_rb_index_i = 0;
    bus.id_ra_used_i = 0; bus.id_rb_used_i = 0; bus.id_ra_value_i = 0; bus.id_rb_value_i = 0;
    bus.id_rd_index_i = 0; bus.id_rd_wr_i = 0; bus.id_load_i = 0;
    bus.ex_alu_res_i = 0; bus.mem_rd_index_i = 0; bus.mem_rd_wr_i = 0; bus.mem_access_i = 0;
    bus.mem_alu_res_i = 0; bus.mem_rdata_i = 0; bus.ex_stall_i = 0; bus.flush_i = 0;
  endtask

  // Place an instruction writing rd into ID; it is in EX after the next edge.
  task automatic issue(input logic [4:0] rd, input logic load);
    @(negedge clk);
    idle();
    bus.id_valid_i = 1; bus.id_rd_index_i = rd; bus.id_rd_wr_i = 1; bus.id_load_i = load;
  endtask

  // Next cycle: ID instruction reading ra (and rb), writing nothing.
  task automatic reader(input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clk);
    idle();
    bus.id_valid_i = 1;
    bus.id_ra_index_i = ra; bus.id_ra_used_i = 1; bus.id_ra_value_i = 32'h99;
    bus.id_rb_index_i = rb; bus.id_rb_used_i = 1; bus.id_rb_value_i = 32'h98;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_ni = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", 32'(bus.ex_valid_o), 0);
    check("reset_count", 32'(bus.stall_count_o), 0);
    check("reset_stall", 32'(bus.id_stall_o), 0);
    reset_ni = 1;

    // Forward from EX
    issue(3, 0);
    reader(3, 0);
    bus.ex_alu_res_i = 32'h11;
    #1 check("exfwd_stall", 32'(bus.id_stall_o), 0);
    after_edge();
    check("exfwd_ra", bus.ex_ra_o, 32'h11);

    // Forward from MEM: ALU result, then load data
    issue(6, 0);
    reader(0, 5);
    bus.ex_alu_res_i = 32'hAA;
    bus.mem_rd_wr_i = 1; bus.mem_rd_index_i = 5; bus.mem_alu_res_i = 32'h22;
    after_edge();
    check("memfwd_alu", bus.ex_rb_o, 32'h22);
    reader(0, 5);
    bus.mem_rd_wr_i = 1; bus.mem_rd_index_i = 5; bus.mem_access_i = 1;
    bus.mem_alu_res_i = 32'h22; bus.mem_rdata_i = 32'h33;
    after_edge();
    check("memfwd_load", bus.ex_rb_o, 32'h33);

    // EX beats MEM; x0 never forwards
    issue(7, 0);
    reader(7, 0);
    bus.ex_alu_res_i = 32'h44;
    bus.mem_rd_wr_i = 1; bus.mem_rd_index_i = 7; bus.mem_alu_res_i = 32'h55;
    after_edge();
    check("prio_ex", bus.ex_ra_o, 32'h44);
    issue(0, 0);
    reader(0, 0);
    bus.id_ra_value_i = 32'h12; bus.ex_alu_res_i = 32'h66;
    bus.mem_rd_wr_i = 1; bus.mem_rd_index_i = 0; bus.mem_alu_res_i = 32'h67;
    after_edge();
    check("x0_ra", bus.ex_ra_o, 32'h12);

    // Load-use: one bubble, then MEM load data
    issue(2, 1);
    reader(2, 0);
    #1 check("lu_stall", 32'(bus.id_stall_o), 1);
    after_edge();
    check("lu_bubble", 32'(bus.ex_valid_o), 0);
    check("lu_count", 32'(bus.stall_count_o), 1);
    @(negedge clk);
    bus.mem_rd_wr_i = 1; bus.mem_rd_index_i = 2; bus.mem_access_i = 1; bus.mem_rdata_i = 32'h77;
    #1 check("lu_release", 32'(bus.id_stall_o), 0);
    after_edge();
    check("lu_ra", bus.ex_ra_o, 32'h77);
    check("lu_valid", 32'(bus.ex_valid_o), 1);

    // Flush wins over load-use
    issue(4, 1);
    reader(4, 0);
    bus.flush_i = 1;
    #1 check("flush_stall", 32'(bus.id_stall_o), 0);
    after_edge();
    check("flush_valid", 32'(bus.ex_valid_o), 0);
    check("flush_count", 32'(bus.stall_count_o), 1);

    // Four more load-use events saturate a 2-bit counter at 3
    for (int i = 0; i < 4; i++) begin
      issue(2, 1);
      reader(2, 0);
    end
    after_edge();
    check("sat_count", 32'(bus.stall_count_o), 3);

    // Asynchronous reset in the middle of a bubble
    issue(2, 1);
    reader(2, 0);
    @(posedge clk);
    #2 reset_ni = 0;
    #1;
    check("areset_valid", 32'(bus.ex_valid_o), 0);
    check("areset_load", 32'(bus.ex_load_o), 0);
    check("areset_rdwr", 32'(bus.ex_rd_wr_o), 0);
    check("areset_ra", bus.ex_ra_o, 0);
    check("areset_count", 32'(bus.stall_count_o), 0);
    check("areset_stall", 32'(bus.id_stall_o), 0);
    @(negedge clk);
    reset_ni = 1;

    // Random traffic; small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!reset_ni) reset_ni = 1;
      bus.id_valid_i     = ($urandom_range(0, 9) < 8);
      bus.id_ra_index_i  = 5'($urandom_range(0, 3));
      bus.id_rb_index_i  = 5'($urandom_range(0, 3));
      bus.id_ra_used_i   = ($urandom_range(0, 9) < 7);
      bus.id_rb_used_i   = ($urandom_range(0, 9) < 7);
      bus.id_ra_value_i  = $urandom;
      bus.id_rb_value_i  = $urandom;
      bus.id_rd_index_i  = 5'($urandom_range(0, 3));
      bus.id_rd_wr_i     = ($urandom_range(0, 9) < 7);
      bus.id_load_i      = ($urandom_range(0, 9) < 4);
      bus.ex_alu_res_i   = $urandom;
      bus.mem_rd_index_i = 5'($urandom_range(0, 3));
      bus.mem_rd_wr_i    = $urandom_range(0, 1) == 1;
      bus.mem_access_i   = $urandom_range(0, 1) == 1;
      bus.mem_alu_res_i  = $urandom;
      bus.mem_rdata_i    = $urandom;
      bus.ex_stall_i     = ($urandom_range(0, 9) == 0);
      bus.flush_i        = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #3 reset_ni = 0;
      end
    end
    @(negedge clk);
    reset_ni = 1;
    idle();
    repeat (2) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
